// File: rtl/ising_core_reg_slv.sv
// Reg-bus responder for one Ising core window: decode, config registers and run control.
// Define ISING_REG_IRQ_EN to add the IRQ_MASK register (offset 0x18) and the irq_o output.
module ising_core_reg_slv #(
    parameter int unsigned          AddrWidth       = 48,
    parameter logic [AddrWidth-1:0] BaseAddr        = '0,
    parameter int unsigned          CounterBitwidth = 32,
    parameter int unsigned          EnergyBit       = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [AddrWidth-1:0] reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    input  logic [3:0]           reg_wstrb_i,
    output logic                 reg_ready_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 start_o,
    output logic [31:0]          cfg_o,
`ifdef ISING_REG_IRQ_EN
    output logic                 irq_o,
`endif
    input  logic                 core_done_i,
    input  logic [EnergyBit-1:0] energy_i
);

    localparam logic [2:0] WordCtrl    = 3'd0;
    localparam logic [2:0] WordStatus  = 3'd1;
    localparam logic [2:0] WordCycles  = 3'd2;
    localparam logic [2:0] WordCfg     = 3'd3;
    localparam logic [2:0] WordElapsed = 3'd4;
    localparam logic [2:0] WordEnergy  = 3'd5;
`ifdef ISING_REG_IRQ_EN
    localparam logic [2:0]           WordIrq = 3'd6;
    localparam logic [AddrWidth-1:0] WinEnd  = AddrWidth'(32'h1C);
`else
    localparam logic [AddrWidth-1:0] WinEnd  = AddrWidth'(32'h18);
`endif

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    function automatic logic [31:0] merge_bytes(logic [31:0] old_val, logic [31:0] wdata,
                                                logic [3:0] strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    state_e                     state_q, state_d;
    logic [31:0]                rdata_q, rdata_d, rd_val;
    logic                       error_q, error_d;
    logic                       busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic                       start_q, start_d;
    logic [CounterBitwidth-1:0] cycles_q, cycles_d, elapsed_q, elapsed_d;
    logic [CounterBitwidth:0]   elapsed_inc;
    logic [EnergyBit-1:0]       energy_q, energy_d;
    logic [31:0]                cfg_q, cfg_d, cycles_wr;
    logic [AddrWidth-1:0]       off;
    logic [2:0]                 word;
    logic                       accept, in_win, ro_hit, dec_err, wr_en;
`ifdef ISING_REG_IRQ_EN
    logic [1:0]                 irq_mask_q, irq_mask_d;
    logic                       irq_q, irq_d;
`endif

    assign off     = reg_addr_i - BaseAddr;
    assign word    = off[4:2];
    assign accept  = (state_q == StIdle) && reg_valid_i;
    assign in_win  = (reg_addr_i >= BaseAddr) && (off < WinEnd) && (off[1:0] == 2'b00);
    assign ro_hit  = (word == WordStatus) || (word == WordElapsed) || (word == WordEnergy);
    assign dec_err = !in_win || (reg_write_i && ro_hit);
    assign wr_en   = accept && reg_write_i && !dec_err;

    always_comb begin
        rd_val = '0;
        case (word)
            WordStatus:  rd_val = {29'b0, timeout_q, done_q, busy_q};
            WordCycles:  rd_val = 32'(cycles_q);
            WordCfg:     rd_val = cfg_q;
            WordElapsed: rd_val = 32'(elapsed_q);
            WordEnergy:  rd_val = 32'(energy_q);
`ifdef ISING_REG_IRQ_EN
            WordIrq:     rd_val = {30'b0, irq_mask_q};
`endif
            default:     rd_val = '0;
        endcase
    end

    // Bus handshake: accept in idle, present the registered response for one cycle.
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (reg_valid_i) begin
                    state_d = StResp;
                    error_d = dec_err;
                    rdata_d = (dec_err || reg_write_i) ? '0 : rd_val;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Run events are applied first so CLR can wipe them; START then overrides both.
    always_comb begin
        busy_d      = busy_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        elapsed_d   = elapsed_q;
        energy_d    = energy_q;
        cycles_d    = cycles_q;
        cfg_d       = cfg_q;
        start_d     = 1'b0;
        cycles_wr   = merge_bytes(32'(cycles_q), reg_wdata_i, reg_wstrb_i);
        elapsed_inc = {1'b0, elapsed_q} + (CounterBitwidth+1)'(1);
`ifdef ISING_REG_IRQ_EN
        irq_mask_d  = irq_mask_q;
`endif
        if (busy_q) begin
            elapsed_d = elapsed_inc[CounterBitwidth] ? elapsed_q
                                                     : elapsed_inc[CounterBitwidth-1:0];
            if (core_done_i) begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                energy_d = energy_i;
            end else if ((cycles_q != '0) && (elapsed_inc == {1'b0, cycles_q})) begin
                busy_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
        if (wr_en) begin
            case (word)
                WordCtrl: begin
                    if (reg_wstrb_i[0] && reg_wdata_i[1]) begin
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        elapsed_d = '0;
                        energy_d  = '0;
                    end
                    if (reg_wstrb_i[0] && reg_wdata_i[0] && !busy_q) begin
                        start_d   = 1'b1;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        elapsed_d = '0;
                    end
                end
                WordCycles: cycles_d = cycles_wr[CounterBitwidth-1:0];
                WordCfg:    cfg_d    = merge_bytes(cfg_q, reg_wdata_i, reg_wstrb_i);
`ifdef ISING_REG_IRQ_EN
                WordIrq:    if (reg_wstrb_i[0]) irq_mask_d = reg_wdata_i[1:0];
`endif
                default: ;
            endcase
        end
`ifdef ISING_REG_IRQ_EN
        irq_d = (done_d & irq_mask_d[0]) | (timeout_d & irq_mask_d[1]);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            start_q    <= 1'b0;
            cycles_q   <= '0;
            elapsed_q  <= '0;
            energy_q   <= '0;
            cfg_q      <= '0;
`ifdef ISING_REG_IRQ_EN
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            start_q    <= start_d;
            cycles_q   <= cycles_d;
            elapsed_q  <= elapsed_d;
            energy_q   <= energy_d;
            cfg_q      <= cfg_d;
`ifdef ISING_REG_IRQ_EN
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign reg_ready_o = (state_q == StResp);
    assign reg_rdata_o = rdata_q;
    assign reg_error_o = error_q;
    assign start_o     = start_q;
    assign cfg_o       = cfg_q;
`ifdef ISING_REG_IRQ_EN
    assign irq_o       = irq_q;
`endif

endmodule
